// File: rtl/instr_encoder_pkg.sv
// Shared RV32I opcode constants, instruction-format selection and the field-to-word packer.
package instr_encoder_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MEM    = 7'b0001111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_U, FMT_B, FMT_S} fmt_e;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fun3;
    logic [6:0]  fun7;
    logic [31:0] imm;
  } fields_t;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_IMM, OP_JALR, OP_LOAD: f = FMT_I;
      OP_LUI, OP_AUIPC, OP_JAL: f = FMT_U;
      OP_BRANCH:                f = FMT_B;
      OP_STORE:                 f = FMT_S;
      default:                  f = FMT_R;
    endcase
    return f;
  endfunction

  function automatic logic is_supported(input logic [6:0] op);
    logic s;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: s = 1'b1;
      default:                          s = 1'b0;
    endcase
    return s;
  endfunction

  // Immediates are taken as raw decoder fields; no RISC-V bit scrambling.
  function automatic logic [31:0] encode(input fields_t f);
    logic [31:0] w;
    case (fmt_of(f.op))
      FMT_I:   w = {f.imm[11:0], f.rs1, f.fun3, f.rd, f.op};
      FMT_U:   w = {f.imm[19:0], f.rd, f.op};
      FMT_B:   w = {f.imm[12:6], f.rs2, f.rs1, f.fun3, f.imm[5:1], f.op};
      FMT_S:   w = {f.imm[11:5], f.rs2, f.rs1, f.fun3, f.imm[4:0], f.op};
      default: w = {f.fun7, f.rs2, f.rs1, f.fun3, f.rd, f.op};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-tuple input handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(parameter int unsigned ADDR_W = 32);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opCode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        fun3;
  logic [6:0]        fun7;
  logic [31:0]       imm;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] count;
  logic              unsup;

  modport master (
    output flush, in_valid, opCode, rd, rs1, rs2, fun3, fun7, imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, unsup
  );

  modport slave (
    input  flush, in_valid, opCode, rd, rs1, rs2, fun3, fun7, imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, count, unsup
  );

endinterface

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO with wrap-bit pointers, active-low reset and synchronous clear.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && rst_n && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  // Equal indices: wrap bits differ when full, match when empty.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words, queues them and streams
// them to instruction memory at an auto-incrementing address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);

  fields_t           w_fields;
  logic [31:0]       w_word;
  logic [31:0]       w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_unused;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic              r_unsup;

  assign w_fields = '{op:   bus.opCode,
                      rd:   bus.rd,
                      rs1:  bus.rs1,
                      rs2:  bus.rs2,
                      fun3: bus.fun3,
                      fun7: bus.fun7,
                      imm:  bus.imm};
  assign w_word   = encode(w_fields);
  assign w_unused = ^bus.imm[31:20];

  // Flush wins over a same-cycle push or pop.
  assign w_push = bus.in_valid && !w_full && !bus.flush;
  assign w_pop  = !w_empty && bus.mem_ready && !bus.flush;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (bus.flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_word),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
      r_unsup <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr  <= r_addr + ADDR_W'(4);
        r_count <= r_count + ADDR_W'(1);
      end
      if (w_push && !is_supported(bus.opCode)) r_unsup <= 1'b1;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.mem_we    = !w_empty;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = w_head;
  assign bus.count     = r_count;
  assign bus.unsup     = r_unsup;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed + random bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;

  localparam logic [6:0] T_LUI = 7'b0110111, T_AUIPC = 7'b0010111, T_JAL = 7'b1101111,
                         T_JALR = 7'b1100111, T_BR = 7'b1100011, T_LD = 7'b0000011,
                         T_ST = 7'b0100011, T_IMM = 7'b0010011, T_OP = 7'b0110011,
                         T_MEM = 7'b0001111, T_SYS = 7'b1110011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(32)) bA ();
  instr_encoder_if #(.ADDR_W(8))  bB ();

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(bA.slave));
  instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(8'hF8)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(bB.slave));

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic [31:0] wr_log[$];
  logic [31:0] m_addr = 0;
  logic [31:0] m_count = 0;
  bit          m_unsup = 0;
  bit          last_push = 0;
  logic [6:0]  ops[11] = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_IMM, T_OP, T_MEM, T_SYS};

  function automatic bit ref_sup(input logic [6:0] op);
    return op inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_IMM, T_OP};
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned op, rd, rs1, rs2, f3, f7, imm);
    int unsigned w;
    if (op == T_IMM || op == T_JALR || op == T_LD)
      w = ((imm % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
    else if (op == T_LUI || op == T_AUIPC || op == T_JAL)
      w = ((imm % 1048576) << 12) + (rd << 7) + op;
    else if (op == T_BR)
      w = (((imm / 64) % 128) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
        + (((imm / 2) % 32) << 7) + op;
    else if (op == T_ST)
      w = (((imm / 32) % 128) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
        + ((imm % 32) << 7) + op;
    else
      w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    bA.opCode = op; bA.rd = rd; bA.rs1 = rs1; bA.rs2 = rs2;
    bA.fun3 = f3; bA.fun7 = f7; bA.imm = imm;
  endtask

  // One clock: update the model from the values present at the edge, then compare.
  task automatic cyc();
    bit push, pop;
    logic [31:0] pre_addr;
    pre_addr = bA.mem_addr;
    @(posedge clk);
    push = 0;
    pop  = 0;
    if (!rst_n || bA.flush) begin
      q.delete();
      m_addr = 0; m_count = 0; m_unsup = 0;
    end else begin
      push = bA.in_valid && (q.size() < 4);
      pop  = (q.size() > 0) && bA.mem_ready;
      if (pop) begin
        void'(q.pop_front());
        m_addr += 4;
        m_count += 1;
        wr_log.push_back(pre_addr);
      end
      if (push) begin
        q.push_back(ref_word(bA.opCode, bA.rd, bA.rs1, bA.rs2, bA.fun3, bA.fun7, bA.imm));
        if (!ref_sup(bA.opCode)) m_unsup = 1;
      end
    end
    last_push = push;
    #1;
    chk("in_ready", bA.in_ready, 32'(q.size() < 4));
    chk("mem_we", bA.mem_we, 32'(q.size() > 0));
    if (q.size() > 0) chk("mem_wdata", bA.mem_wdata, q[0]);
    chk("mem_addr", bA.mem_addr, m_addr);
    chk("count", bA.count, m_count);
    chk("unsup", bA.unsup, 32'(m_unsup));
  endtask

  task automatic push_check(input string tag, input logic [31:0] exp);
    bA.in_valid = 1;
    cyc();
    bA.in_valid = 0;
    chk(tag, bA.mem_wdata, exp);
    cyc();
  endtask

  initial begin
    int idx;
    bA.flush = 0; bA.in_valid = 0; bA.mem_ready = 0;
    bB.flush = 0; bB.in_valid = 0; bB.mem_ready = 0;
    bB.opCode = T_IMM; bB.rd = 1; bB.rs1 = 0; bB.rs2 = 0; bB.fun3 = 0; bB.fun7 = 0; bB.imm = 5;
    drive(T_IMM, 1, 0, 0, 0, 0, 5);

    // Reset state
    cyc(); cyc();
    chk("rst_B_addr", bB.mem_addr, 32'hF8);
    chk("rst_B_we", bB.mem_we, 0);
    rst_n = 1;
    cyc();

    // addi x1,x0,5 lands at address 0 one cycle after the push
    bA.mem_ready = 1;
    drive(T_IMM, 1, 0, 0, 0, 0, 5);
    bA.in_valid = 1;
    cyc();
    bA.in_valid = 0;
    chk("addi_word", bA.mem_wdata, 32'h00500093);
    chk("addi_addr", bA.mem_addr, 32'h0);
    chk("addi_we", bA.mem_we, 1);
    cyc();

    drive(T_OP, 3, 1, 2, 0, 0, 0);         push_check("add_word", 32'h002081B3);
    drive(T_LUI, 5, 0, 0, 0, 0, 32'h12345); push_check("lui_word", 32'h123452B7);
    drive(T_ST, 0, 1, 2, 2, 0, 8);         push_check("sw_word", 32'h0020A423);
    drive(T_BR, 0, 1, 2, 0, 0, 16);        push_check("beq_word", 32'h00208463);

    // Narrow address counter wraps modulo 2**8
    bB.in_valid = 1;
    cyc(); cyc(); cyc();
    bB.in_valid = 0;
    bB.mem_ready = 1;
    chk("wrap_a0", bB.mem_addr, 32'hF8); cyc();
    chk("wrap_a1", bB.mem_addr, 32'hFC); cyc();
    chk("wrap_a2", bB.mem_addr, 32'h00); cyc();
    chk("wrap_cnt", bB.count, 3);
    chk("wrap_we", bB.mem_we, 0);
    bB.mem_ready = 0;

    // Fill to DEPTH with memory stalled, then drain
    bA.flush = 1; cyc(); bA.flush = 0;
    wr_log.delete();
    bA.mem_ready = 0;
    idx = 0;
    for (int n = 0; n < 40 && idx < 5; n++) begin
      drive(T_IMM, 5'(idx + 1), 5'(idx), 0, 0, 0, 32'(idx * 3));
      bA.in_valid = 1;
      if (n == 7) bA.mem_ready = 1;
      cyc();
      if (last_push) begin
        if (idx == 3) chk("full_in_ready", bA.in_ready, 0);
        idx++;
      end
    end
    bA.in_valid = 0;
    chk("fill_pushed", idx, 5);
    for (int n = 0; n < 20 && q.size() > 0; n++) cyc();
    chk("drain_empty", bA.mem_we, 0);
    chk("drain_count", bA.count, 5);
    chk("drain_nlog", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("drain_addr", wr_log[i], 32'(i * 4));

    // Sticky unsup, cleared by flush; flush beats a same-cycle push
    drive(T_MEM, 1, 2, 3, 0, 0, 0);
    bA.in_valid = 1; cyc(); bA.in_valid = 0;
    chk("unsup_set", bA.unsup, 1);
    cyc(); cyc(); cyc();
    chk("unsup_sticky", bA.unsup, 1);
    drive(T_IMM, 1, 0, 0, 0, 0, 1);
    bA.flush = 1; bA.in_valid = 1; cyc(); bA.flush = 0; bA.in_valid = 0;
    chk("flush_unsup", bA.unsup, 0);
    chk("flush_we", bA.mem_we, 0);
    chk("flush_addr", bA.mem_addr, 0);
    chk("flush_count", bA.count, 0);

    // Reset with words queued behind a stalled memory
    bA.mem_ready = 0;
    bA.in_valid = 1; cyc(); cyc(); cyc(); bA.in_valid = 0;
    rst_n = 0; cyc(); rst_n = 1;
    chk("midrst_we", bA.mem_we, 0);
    chk("midrst_count", bA.count, 0);
    chk("midrst_ready", bA.in_ready, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int unsigned k;
      k = $urandom_range(0, 11);
      drive((k == 11) ? 7'($urandom) : ops[k], 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), $urandom);
      bA.in_valid  = 1'($urandom_range(0, 1));
      bA.mem_ready = ($urandom_range(0, 3) != 0);
      bA.flush     = ($urandom_range(0, 39) == 0);
      rst_n        = ($urandom_range(0, 79) != 0);
      cyc();
    end
    bA.flush = 0; rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
